fht16_ctrl: RTL and testbench

Sequencer for the 16-lane radix-2 Hadamard butterfly stage. Collects 16 chip-rate samples and drives the external registered stage through four in-place passes, giving a 16-point fast Hadamard transform. Scales between passes so every value fits the stage's 15-bit inputs. Then scans the 16 results serially and reports the index and magnitude of the strongest correlation (code number) to the despreader.

---
 rtl/fht16_if.sv | 23 ++
 rtl/fht16_ctrl.sv | 150 +++++++++++++++
 tb/tb_fht16_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fht16_if.sv
// Handshake and stage bus for the 16-point FHT sequencer.
// The slave side is the sequencer; the master side is the sample source, stage and despreader.
interface fht16_if #(parameter int IN_W = 14);
  logic            InValid;
  logic [IN_W-1:0] InData;
  logic            InReady;
  logic            FhtStar;
  logic [239:0]    StIn;
  logic [255:0]    StOut;
  logic            Busy;
  logic            Done;
  logic [3:0]      Location;
  logic [15:0]     PeakMag;

  modport master (
    output InValid, InData, StOut,
    input  InReady, FhtStar, StIn, Busy, Done, Location, PeakMag
  );
  modport slave (
    input  InValid, InData, StOut,
    output InReady, FhtStar, StIn, Busy, Done, Location, PeakMag
  );
endinterface

// File: rtl/fht16_ctrl.sv
// 16-point fast Hadamard transform sequencer: loads 16 samples, runs four in-place
// passes through the external butterfly stage, then serially searches for the peak |result|.
module fht16_lane (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ld,
  input  logic [15:0] ld_val,
  input  logic        cap,
  input  logic        shift,
  input  logic [15:0] st_out,
  output logic [15:0] q
);
  always_ff @(posedge Clk) begin
    if (Reset)    q <= '0;
    else if (ld)  q <= ld_val;
    else if (cap) q <= shift ? {st_out[15], st_out[15:1]} : st_out;
  end
endmodule

module fht16_ctrl #(
  parameter int IN_W = 14
) (
  input logic     Clk,
  input logic     Reset,
  fht16_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, LOAD, PASS, SEARCH, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [1:0]        pass;
  logic              phase;   // 0: issue, 1: capture
  logic [15:0][15:0] bufq;
  logic              in_ready, fht_star, busy, done;
  logic [3:0]        loc_q, pk_loc, nxt_loc;
  logic [15:0]       mag_q, pk_mag, nxt_mag, mag;
  logic signed [15:0] cur;
  logic              accept, cap, shift, better;
  logic [15:0]       smp;

  assign accept = bus.InValid & in_ready;
  assign smp    = {{(16-IN_W){bus.InData[IN_W-1]}}, bus.InData};
  assign cap    = (state == PASS) && phase;
  // Halving after the first three passes keeps every stage input within 15 bits.
  assign shift  = (pass != 2'd3);

  // cnt doubles as load slot and search index; it is 0 whenever IDLE.
  for (genvar i = 0; i < 16; i++) begin : g_lane
    fht16_lane u_lane (
      .Clk    (Clk),
      .Reset  (Reset),
      .ld     (accept && (cnt == 4'(i))),
      .ld_val (smp),
      .cap    (cap),
      .shift  (shift),
      .st_out (bus.StOut[16*i +: 16]),
      .q      (bufq[i])
    );
    assign bus.StIn[15*i +: 15] = bufq[i][14:0];
  end

  assign cur = bufq[cnt];

  always_comb begin
    mag = cur[15] ? 16'(-cur) : 16'(cur);
    if (cur == 16'sh8000) mag = 16'd32767;
  end

  assign better  = mag > pk_mag;
  assign nxt_mag = better ? mag : pk_mag;
  assign nxt_loc = better ? cnt : pk_loc;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      pass     <= '0;
      phase    <= 1'b0;
      in_ready <= 1'b1;
      fht_star <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      loc_q    <= '0;
      mag_q    <= '0;
      pk_loc   <= '0;
      pk_mag   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt   <= 4'd1;
          state <= LOAD;
        end
        LOAD: if (accept) begin
          if (cnt == 4'd15) begin
            state    <= PASS;
            pass     <= '0;
            phase    <= 1'b0;
            fht_star <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        PASS: if (!phase) begin
          phase    <= 1'b1;
          fht_star <= 1'b0;
        end else begin
          phase <= 1'b0;
          if (pass == 2'd3) begin
            state  <= SEARCH;
            cnt    <= '0;
            pk_mag <= '0;
            pk_loc <= '0;
          end else begin
            pass     <= pass + 2'd1;
            fht_star <= 1'b1;
          end
        end
        SEARCH: begin
          pk_mag <= nxt_mag;
          pk_loc <= nxt_loc;
          if (cnt == 4'd15) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            loc_q <= nxt_loc;
            mag_q <= nxt_mag;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.FhtStar  = fht_star;
  assign bus.Busy     = busy;
  assign bus.Done     = done;
  assign bus.Location = loc_q;
  assign bus.PeakMag  = mag_q;
endmodule

// File: tb/tb_fht16_ctrl.sv
// Bench for fht16_ctrl: behavioural shuffle-butterfly stage, expected peaks queued per block.
module tb_fht16_ctrl;
  localparam int IN_W = 14;

  typedef struct {int loc; int mag; int dcyc;} exp_t;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  fht16_if #(.IN_W(IN_W)) ifc();
  fht16_ctrl #(.IN_W(IN_W)) dut (.Clk(Clk), .Reset(Reset), .bus(ifc));

  exp_t q[$];
  exp_t e_cur;
  int   cyc = 0;
  int   t0 = 0;
  bit   t0_vld = 0;
  bit   star_prev = 0;
  int   d;
  int   nasrt = 0, nfail = 0;
  logic [255:0] st_q = '0;

  // Perfect-shuffle butterfly: out[2k] = in[k] + in[k+8], out[2k+1] = in[k] - in[k+8].
  function automatic logic [255:0] stage(input logic [239:0] si);
    logic [255:0] r;
    logic signed [14:0] a, b;
    logic signed [15:0] s, df;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      a  = si[15*k +: 15];
      b  = si[15*(k+8) +: 15];
      s  = a + b;
      df = a - b;
      r[16*(2*k) +: 16]   = s;
      r[16*(2*k+1) +: 16] = df;
    end
    return r;
  endfunction

  always @(posedge Clk) if (ifc.FhtStar) st_q <= stage(ifc.StIn);
  assign ifc.StOut = st_q;
  always @(posedge Clk) cyc <= cyc + 1;

  // Reference: Sylvester-ordered FHT with halving after passes 0..2, then peak search.
  function automatic void model(input int x[16], output int loc, output int mag);
    int a[16], v[16], m;
    a = x;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 8; k++) begin
        v[2*k]   = a[k] + a[k+8];
        v[2*k+1] = a[k] - a[k+8];
      end
      for (int i = 0; i < 16; i++) a[i] = (p < 3) ? (v[i] >>> 1) : v[i];
    end
    loc = 0; mag = 0;
    for (int j = 0; j < 16; j++) begin
      m = (a[j] < 0) ? -a[j] : a[j];
      if (m > 32767) m = 32767;
      if (m > mag) begin mag = m; loc = j; end
    end
  endfunction

  function automatic int hrow(input int k, input int i);
    return ($countones(k & i) % 2) ? -1 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int x[16], input int el, input int em, input int maxgap, input bit hold);
    bit acc;
    int wt, g;
    for (int n = 0; n < 16; n++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap)) : 0;
      repeat (g) begin ifc.InValid = 1'b0; @(posedge Clk); #1; end
      ifc.InValid = 1'b1;
      ifc.InData  = IN_W'(x[n]);
      acc = 0; wt = 0;
      while (!acc && wt < 100) begin
        @(negedge Clk);
        acc = ifc.InReady;
        if (acc && n == 15) begin
          t0 = cyc; t0_vld = 1;
          q.push_back('{el, em, cyc + 25});
        end
        @(posedge Clk); #1;
        wt++;
      end
      if (!acc) begin check("accept_timeout", 32'(acc), 1); return; end
    end
    ifc.InValid = hold;
    ifc.InData  = IN_W'(-7777);
  endtask

  task automatic wait_done();
    int w = 0;
    while (q.size() > 0 && w < 200) begin @(posedge Clk); #1; w++; end
    check("done_timeout", 32'(q.size()), 0);
  endtask

  always @(negedge Clk) begin
    if (ifc.Done) begin
      check("sb_nonempty", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e_cur = q.pop_front();
        check("location", 32'(ifc.Location), e_cur.loc);
        check("peakmag", 32'(ifc.PeakMag), e_cur.mag);
        check("done_cycle", cyc, e_cur.dcyc);
      end
    end
    if (t0_vld) begin
      d = cyc - t0;
      if (d >= 1 && d <= 25) check("inready_low", 32'(ifc.InReady), 0);
      if (d == 26)           check("inready_high", 32'(ifc.InReady), 1);
      if (d >= 1 && d <= 24) check("busy_high", 32'(ifc.Busy), 1);
      if (d == 25)           check("busy_low", 32'(ifc.Busy), 0);
      if (d >= 1 && d <= 25) check("fhtstar_slot", 32'(ifc.FhtStar), 32'(d % 2 == 1 && d <= 7));
    end
    if (ifc.FhtStar) check("fhtstar_consec", 32'(star_prev), 0);
    star_prev <= ifc.FhtStar;
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_fhtstar"}, 32'(ifc.FhtStar), 0);
    check({tag, "_busy"}, 32'(ifc.Busy), 0);
    check({tag, "_done"}, 32'(ifc.Done), 0);
    check({tag, "_loc"}, 32'(ifc.Location), 0);
    check({tag, "_mag"}, 32'(ifc.PeakMag), 0);
    check({tag, "_stin"}, 32'(ifc.StIn == '0), 1);
  endtask

  initial begin
    int xc[16], xs[16], xn[16], xm[16], xt[16], xr[16];
    int el, em;
    for (int i = 0; i < 16; i++) begin
      xc[i] = 100;
      xs[i] = (i < 8) ? 100 : -100;
      xn[i] = -100;
      xm[i] = -8192;
      xt[i] = 100 * (hrow(3, i) + hrow(5, i));
    end

    // Reset, with samples offered during reset that must be dropped
    Reset = 1'b1; ifc.InValid = 1'b1; ifc.InData = IN_W'(500);
    repeat (3) begin @(posedge Clk); #1; end
    @(negedge Clk);
    check_idle_outputs("rst");
    @(posedge Clk); #1;
    Reset = 1'b0; ifc.InValid = 1'b0;
    @(negedge Clk);
    check("rst_inready", 32'(ifc.InReady), 1);
    @(posedge Clk); #1;

    send(xc, 0, 200, 0, 0);    wait_done();
    send(xs, 8, 200, 0, 0);    wait_done();
    send(xn, 0, 200, 0, 0);    wait_done();
    send(xm, 0, 16384, 0, 0);  wait_done();

    // InValid held through the busy window with garbage data, then a back-to-back block
    send(xc, 0, 200, 0, 1);
    repeat (10) begin @(posedge Clk); #1; end
    send(xs, 8, 200, 0, 0);    wait_done();

    send(xc, 0, 200, 3, 0);    wait_done();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) xr[i] = int'($urandom_range(16383)) - 8192;
      model(xr, el, em);
      send(xr, el, em, 2, 0);  wait_done();
    end
    send(xt, 3, 200, 0, 0);    wait_done();

    // Reset in T+4, mid-PASS
    send(xc, 0, 200, 0, 0);
    repeat (3) begin @(posedge Clk); #1; end
    t0_vld = 0;
    q.delete();
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check_idle_outputs("midrst");
    check("midrst_inready", 32'(ifc.InReady), 1);
    repeat (4) begin
      @(negedge Clk);
      check("midrst_idle_star", 32'(ifc.FhtStar), 0);
    end
    @(posedge Clk); #1;
    send(xc, 0, 200, 0, 0);    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end
endmodule
